// File: rtl/rgb_hue_engine_if.sv
// Hue-load command handshake between a controller and rgb_hue_engine.
interface rgb_hue_engine_if #(
    parameter int unsigned HUE_W = 9
);
    logic             cmd_valid;
    logic [HUE_W-1:0] cmd_hue;
    logic             cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_hue,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_hue,
        output cmd_ready
    );
endinterface

// File: rtl/rgb_hue_engine.sv
// Hue-wheel RGB LED driver: cycling/holding/bouncing hue, colour-wheel mapping and PWM outputs.
// Optional feature: define RGB_BRIGHTNESS_EN to scale every duty by the brightness input.
module rgb_hue_engine #(
    parameter int unsigned CLK_FREQ  = 12_000_000,
    parameter int unsigned PWM_W     = 8,
    parameter int unsigned SEG_STEPS = 60,
    localparam int unsigned HUE_N    = 6 * SEG_STEPS,
    localparam int unsigned HUE_W    = $clog2(HUE_N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               dir,
    rgb_hue_engine_if.slave    cmd,
    input  logic [PWM_W-1:0]   brightness,
    output logic               red_led,
    output logic               green_led,
    output logic               blue_led,
    output logic [HUE_W-1:0]   hue_out,
    output logic               wrap_pulse
);
    localparam int unsigned CYCLES_PER_STEP = CLK_FREQ / HUE_N;
    localparam int unsigned PRE_W = (CYCLES_PER_STEP > 1) ? $clog2(CYCLES_PER_STEP) : 1;
    localparam int unsigned MAX = (2 ** PWM_W) - 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYCLES_PER_STEP - 1);
    localparam logic [HUE_W-1:0] HUE_LAST = HUE_W'(HUE_N - 1);
    localparam logic [PWM_W-1:0] MAX_V    = PWM_W'(MAX);
    localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'(MAX - 1);

    typedef enum logic [1:0] {
        ModeCycle  = 2'd0,
        ModeHold   = 2'd1,
        ModeBounce = 2'd2,
        ModeOff    = 2'd3
    } mode_e;

    logic [PRE_W-1:0] prescaler;
    logic             tick;
    logic [HUE_W-1:0] hue;
    logic             bounce_up;
    logic             pending;
    logic [HUE_W-1:0] pend_hue;

    logic [2:0]       seg;
    logic [PWM_W-1:0] ramp;
    logic [PWM_W-1:0] col_r_d, col_g_d, col_b_d;
    logic [PWM_W-1:0] col_r, col_g, col_b;
    logic [PWM_W-1:0] duty_r, duty_g, duty_b;
    logic [PWM_W-1:0] act_r, act_g, act_b;
    logic [PWM_W-1:0] cmp_r, cmp_g, cmp_b;
    logic [PWM_W-1:0] pwm_cnt;

    assign tick          = (prescaler == PRE_LAST);
    assign cmd.cmd_ready = ~pending;
    assign hue_out       = hue;

    always_comb begin
        seg     = 3'(32'(hue) / SEG_STEPS);
        ramp    = PWM_W'(((32'(hue) % SEG_STEPS) * MAX) / SEG_STEPS);
        col_r_d = '0;
        col_g_d = '0;
        col_b_d = '0;
        case (seg)
            3'd0: begin col_r_d = MAX_V;        col_g_d = ramp;         col_b_d = '0;           end
            3'd1: begin col_r_d = MAX_V - ramp; col_g_d = MAX_V;        col_b_d = '0;           end
            3'd2: begin col_r_d = '0;           col_g_d = MAX_V;        col_b_d = ramp;         end
            3'd3: begin col_r_d = '0;           col_g_d = MAX_V - ramp; col_b_d = MAX_V;        end
            3'd4: begin col_r_d = ramp;         col_g_d = '0;           col_b_d = MAX_V;        end
            3'd5: begin col_r_d = MAX_V;        col_g_d = '0;           col_b_d = MAX_V - ramp; end
            default: ;
        endcase
    end

`ifdef RGB_BRIGHTNESS_EN
    function automatic logic [PWM_W-1:0] scale(input logic [PWM_W-1:0] c,
                                               input logic [PWM_W-1:0] b);
        return PWM_W'((32'(c) * 32'(b)) / MAX);
    endfunction

    assign duty_r = scale(col_r, brightness);
    assign duty_g = scale(col_g, brightness);
    assign duty_b = scale(col_b, brightness);
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign duty_r = col_r;
    assign duty_g = col_g;
    assign duty_b = col_b;
`endif

    // New duties are latched at counter 0; compare against them in that same cycle so a
    // whole PWM period always uses one consistent duty.
    assign cmp_r = (pwm_cnt == '0) ? duty_r : act_r;
    assign cmp_g = (pwm_cnt == '0) ? duty_g : act_g;
    assign cmp_b = (pwm_cnt == '0) ? duty_b : act_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler  <= '0;
            hue        <= '0;
            bounce_up  <= 1'b1;
            pending    <= 1'b0;
            pend_hue   <= '0;
            wrap_pulse <= 1'b0;
            col_r      <= '0;
            col_g      <= '0;
            col_b      <= '0;
            act_r      <= '0;
            act_g      <= '0;
            act_b      <= '0;
            pwm_cnt    <= '0;
            red_led    <= 1'b0;
            green_led  <= 1'b0;
            blue_led   <= 1'b0;
        end else begin
            prescaler  <= tick ? '0 : prescaler + 1'b1;
            wrap_pulse <= 1'b0;

            if (cmd.cmd_valid && !pending) begin
                pending  <= 1'b1;
                pend_hue <= (32'(cmd.cmd_hue) >= HUE_N) ? '0 : cmd.cmd_hue;
            end

            if (tick) begin
                if (pending) begin
                    hue     <= pend_hue;
                    pending <= 1'b0;
                end else begin
                    case (mode_e'(mode))
                        ModeCycle: begin
                            if (!dir) begin
                                if (hue == HUE_LAST) begin
                                    hue        <= '0;
                                    wrap_pulse <= 1'b1;
                                end else begin
                                    hue <= hue + 1'b1;
                                end
                            end else if (hue == '0) begin
                                hue        <= HUE_LAST;
                                wrap_pulse <= 1'b1;
                            end else begin
                                hue <= hue - 1'b1;
                            end
                        end
                        ModeBounce: begin
                            if (bounce_up) begin
                                if (hue == HUE_LAST) begin
                                    hue        <= HUE_LAST - 1'b1;
                                    bounce_up  <= 1'b0;
                                    wrap_pulse <= 1'b1;
                                end else begin
                                    hue <= hue + 1'b1;
                                end
                            end else if (hue == '0) begin
                                hue        <= HUE_W'(1);
                                bounce_up  <= 1'b1;
                                wrap_pulse <= 1'b1;
                            end else begin
                                hue <= hue - 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            col_r <= col_r_d;
            col_g <= col_g_d;
            col_b <= col_b_d;

            pwm_cnt <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + 1'b1;
            if (pwm_cnt == '0) begin
                act_r <= duty_r;
                act_g <= duty_g;
                act_b <= duty_b;
            end

            red_led   <= (mode != ModeOff) && (pwm_cnt < cmp_r);
            green_led <= (mode != ModeOff) && (pwm_cnt < cmp_g);
            blue_led  <= (mode != ModeOff) && (pwm_cnt < cmp_b);
        end
    end
endmodule

// File: tb/tb_rgb_hue_engine.sv
// Self-checking bench for rgb_hue_engine: colour table, cycle/bounce wrap, command and reset cases.
module tb_rgb_hue_engine;
    localparam int unsigned CLK_FREQ  = 1440;
    localparam int unsigned PWM_W     = 8;
    localparam int unsigned SEG_STEPS = 60;
    localparam int unsigned HUE_W     = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode;
    logic             dir;
    logic [PWM_W-1:0] brightness;
    logic             red_led, green_led, blue_led;
    logic [HUE_W-1:0] hue_out;
    logic             wrap_pulse;

    rgb_hue_engine_if #(.HUE_W(HUE_W)) cmd_if ();

    rgb_hue_engine #(
        .CLK_FREQ  (CLK_FREQ),
        .PWM_W     (PWM_W),
        .SEG_STEPS (SEG_STEPS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .dir        (dir),
        .cmd        (cmd_if),
        .brightness (brightness),
        .red_led    (red_led),
        .green_led  (green_led),
        .blue_led   (blue_led),
        .hue_out    (hue_out),
        .wrap_pulse (wrap_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hue_in;
        int exp_hue;
        int exp_r;
        int exp_g;
        int exp_b;
    } vec_t;

    vec_t vecs[9];
    int   exp_q[$];
    int   trace[16];
    int   ptrace[16];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int h, input int exp_h);
        int n = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_hue   = HUE_W'(h);
        exp_q.push_back(exp_h);
        while (!cmd_if.cmd_ready && n < 20) begin
            step();
            n++;
        end
        step();
        cmd_if.cmd_valid = 1'b0;
        check("ready_drop", int'(cmd_if.cmd_ready), 0);
    endtask

    task automatic wait_apply();
        int n = 0;
        int e;
        while (!cmd_if.cmd_ready && n < 20) begin
            step();
            n++;
        end
        check("apply_in_time", int'(cmd_if.cmd_ready), 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check("apply_hue", int'(hue_out), e);
    endtask

    task automatic load_hold(input int h, input int exp_h);
        mode = 2'd1;
        send_cmd(h, exp_h);
        wait_apply();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            trace[i]  = int'(hue_out);
            ptrace[i] = int'(wrap_pulse);
        end
    endtask

    function automatic int pulse_sum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += ptrace[i];
        return s;
    endfunction

    task automatic measure(output int r, output int g, output int b);
        r = 0;
        g = 0;
        b = 0;
        repeat (260) step();
        for (int i = 0; i < 255; i++) begin
            step();
            r += int'(red_led);
            g += int'(green_led);
            b += int'(blue_led);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r, g, b, highs;

        vecs[0] = '{hue_in: 0,   exp_hue: 0,   exp_r: 255, exp_g: 0,   exp_b: 0};
        vecs[1] = '{hue_in: 30,  exp_hue: 30,  exp_r: 255, exp_g: 127, exp_b: 0};
        vecs[2] = '{hue_in: 60,  exp_hue: 60,  exp_r: 255, exp_g: 255, exp_b: 0};
        vecs[3] = '{hue_in: 90,  exp_hue: 90,  exp_r: 128, exp_g: 255, exp_b: 0};
        vecs[4] = '{hue_in: 150, exp_hue: 150, exp_r: 0,   exp_g: 255, exp_b: 127};
        vecs[5] = '{hue_in: 200, exp_hue: 200, exp_r: 0,   exp_g: 170, exp_b: 255};
        vecs[6] = '{hue_in: 270, exp_hue: 270, exp_r: 127, exp_g: 0,   exp_b: 255};
        vecs[7] = '{hue_in: 359, exp_hue: 359, exp_r: 255, exp_g: 0,   exp_b: 5};
        vecs[8] = '{hue_in: 400, exp_hue: 0,   exp_r: 255, exp_g: 0,   exp_b: 0};

        rst              = 1'b1;
        mode             = 2'd1;
        dir              = 1'b0;
        brightness       = 8'd255;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_hue   = '0;
        repeat (3) step();
        check("rst_hue", int'(hue_out), 0);
        check("rst_ready", int'(cmd_if.cmd_ready), 1);
        check("rst_wrap", int'(wrap_pulse), 0);
        check("rst_leds", int'(red_led) + int'(green_led) + int'(blue_led), 0);

        // Free-running cycle from reset: first step after 4 clocks.
        rst  = 1'b0;
        mode = 2'd0;
        run(16);
        check("cyc_hold_3clk", trace[2], 0);
        check("cyc_first_step", trace[3], 1);
        check("cyc_second_step", trace[7], 2);
        check("cyc_fourth_step", trace[15], 4);

        load_hold(358, 358);
        mode = 2'd0;
        dir  = 1'b0;
        run(10);
        check("up_359", trace[3], 359);
        check("up_wrap_hue", trace[7], 0);
        check("up_wrap_pulse", ptrace[7], 1);
        check("up_pulse_count", pulse_sum(10), 1);

        load_hold(0, 0);
        mode = 2'd0;
        dir  = 1'b1;
        run(10);
        check("dn_wrap_hue", trace[3], 359);
        check("dn_wrap_pulse", ptrace[3], 1);
        check("dn_next", trace[7], 358);
        check("dn_pulse_count", pulse_sum(10), 1);

        // Command presented in the tick cycle is applied one tick later.
        load_hold(100, 100);
        mode = 2'd0;
        dir  = 1'b0;
        repeat (3) step();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_hue   = HUE_W'(400);
        exp_q.push_back(0);
        step();
        cmd_if.cmd_valid = 1'b0;
        check("tickcmd_step", int'(hue_out), 101);
        check("tickcmd_ready_low", int'(cmd_if.cmd_ready), 0);
        repeat (3) step();
        check("tickcmd_still", int'(hue_out), 101);
        step();
        check("tickcmd_ready_high", int'(cmd_if.cmd_ready), 1);
        check("tickcmd_hue", int'(hue_out), exp_q.pop_front());
        check("tickcmd_no_wrap", int'(wrap_pulse), 0);

        // Bounce ignores dir; reverse at the top then at the bottom.
        load_hold(358, 358);
        mode = 2'd2;
        dir  = 1'b1;
        run(12);
        check("bnc_up_359", trace[3], 359);
        check("bnc_rev_358", trace[7], 358);
        check("bnc_rev_pulse", ptrace[7], 1);
        check("bnc_357", trace[11], 357);
        check("bnc_top_pulses", pulse_sum(12), 1);

        load_hold(1, 1);
        mode = 2'd2;
        dir  = 1'b0;
        run(12);
        check("bnc_dn_0", trace[3], 0);
        check("bnc_dn_nopulse", ptrace[3], 0);
        check("bnc_rev_1", trace[7], 1);
        check("bnc_rev1_pulse", ptrace[7], 1);
        check("bnc_2", trace[11], 2);

        dir = 1'b0;
        foreach (vecs[i]) begin
            load_hold(vecs[i].hue_in, vecs[i].exp_hue);
            measure(r, g, b);
            check($sformatf("duty_r_hue%0d", vecs[i].hue_in), r, vecs[i].exp_r);
            check($sformatf("duty_g_hue%0d", vecs[i].hue_in), g, vecs[i].exp_g);
            check($sformatf("duty_b_hue%0d", vecs[i].hue_in), b, vecs[i].exp_b);
        end

        load_hold(90, 90);
        measure(r, g, b);
        check("pre_off_red", r, 128);
        mode = 2'd3;
        step();
        check("off_first_cycle", int'(red_led) + int'(green_led) + int'(blue_led), 0);
        highs = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            highs += int'(red_led) + int'(green_led) + int'(blue_led);
        end
        check("off_leds_low", highs, 0);
        check("off_hue_held", int'(hue_out), 90);

        // Reset while a load is pending discards it.
        mode             = 2'd1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_hue   = HUE_W'(200);
        step();
        cmd_if.cmd_valid = 1'b0;
        check("pend_ready_low", int'(cmd_if.cmd_ready), 0);
        rst = 1'b1;
        step();
        check("pend_rst_ready", int'(cmd_if.cmd_ready), 1);
        check("pend_rst_hue", int'(hue_out), 0);
        rst = 1'b0;
        run(10);
        check("pend_discarded", trace[9], 0);

        load_hold(0, 0);
        brightness = 8'd128;
        measure(r, g, b);
`ifdef RGB_BRIGHTNESS_EN
        check("bright_red", r, 128);
`else
        check("bright_red", r, 255);
`endif
        check("bright_green", g, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rgb_hue_engine.md
RGB_HUE_ENGINE -- requirements
Module: rgb_hue_engine

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 12_000_000: clock frequency in Hz.
REQ-002 SHALL have parameter PWM_W, default 8: duty/PWM width; MAX = 2^PWM_W-1.
REQ-003 SHALL have parameter SEG_STEPS, default 60: hue steps per colour segment; HUE_N = 6*SEG_STEPS; HUE_W = $clog2(HUE_N).
REQ-004 SHALL have derived localparam CYCLES_PER_STEP = CLK_FREQ/HUE_N.
REQ-005 SHALL have port clk, input, 1: sole clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port mode, input, 2: 0 CYCLE, 1 HOLD, 2 BOUNCE, 3 OFF.
REQ-008 SHALL have port dir, input, 1: CYCLE direction, 0 up, 1 down.
REQ-009 SHALL have port cmd_valid, input, 1: hue load request.
REQ-010 SHALL have port cmd_hue, input, HUE_W: requested hue.
REQ-011 SHALL have port cmd_ready, output, 1: high when no load is pending.
REQ-012 SHALL have port brightness, input, PWM_W: global brightness scale.
REQ-013 SHALL have ports red_led, green_led and blue_led, each an output of width 1: PWM outputs.
REQ-014 SHALL have port hue_out, output, HUE_W: current hue register.
REQ-015 SHALL have port wrap_pulse, output, 1: one-cycle event at wrap or reversal.

Function
REQ-016 Prescaler SHALL count 0..CYCLES_PER_STEP-1 in all modes; tick = prescaler at terminal count.
REQ-017 CYCLE mode tick SHALL apply hue ± 1 per dir; 359→0 going up and 0→359 going down (HUE_N-1 generally), with wrap_pulse high that cycle.
REQ-018 HOLD and OFF mode ticks SHALL leave hue unchanged.
REQ-019 BOUNCE mode tick SHALL step hue per an internal bounce_up flag, ignoring dir. At hue HUE_N-1 going up, the step reverses to HUE_N-2 and flips the flag. At hue 0 going down, the step goes to 1 and flips the flag. Each reversal pulses wrap_pulse.
REQ-020 cmd_valid && cmd_ready SHALL latch the value (cmd_hue >= HUE_N → 0) as pending and drop cmd_ready the next cycle.
REQ-021 On a tick with a pending load, hue SHALL take the pending value instead of stepping, with no wrap_pulse; pending then clears and cmd_ready rises the next cycle.
REQ-022 A command accepted in a tick cycle SHALL apply at the following tick.
REQ-023 Colour from seg = hue/SEG_STEPS, ramp = ((hue%SEG_STEPS)*MAX)/SEG_STEPS, floor, full-width intermediate (R,G,B):
- seg0: MAX, ramp, 0
- seg1: MAX-ramp, MAX, 0
- seg2: 0, MAX, ramp
- seg3: 0, MAX-ramp, MAX
- seg4: ramp, 0, MAX
- seg5: MAX, 0, MAX-ramp
REQ-024 Colour values SHALL be registered with one cycle of latency after a hue change.
REQ-025 The PWM counter SHALL run 0..MAX-1, period MAX cycles; each LED is high while counter < active duty; duty 0 = constant low, MAX = constant high.
REQ-026 Active duties SHALL update only when the PWM counter is 0, keeping outputs glitch-free.
REQ-027 OFF mode SHALL force all three LEDs low from the cycle after mode=3 is sampled, independent of PWM phase.
REQ-028 A mode change SHALL take effect at the next tick; the bounce_up flag is retained across mode changes.

Reset
REQ-029 While rst is high at a clock edge, the following SHALL be 0:
- hue, prescaler, PWM counter
- colour and active duties
- pending, all LED outputs, wrap_pulse
REQ-030 While rst is high at a clock edge, bounce_up SHALL be 1 and cmd_ready SHALL be 1.
REQ-031 rst asserted mid-operation SHALL discard any pending command and abort the PWM period at that edge.

Configuration
REQ-032 With RGB_BRIGHTNESS_EN defined, each duty SHALL be floor(colour*brightness/MAX), so brightness MAX is identity and 0 is dark.
REQ-033 Without RGB_BRIGHTNESS_EN, duty SHALL equal colour; brightness is ignored and no multiplier is synthesised.

Verification (CLK_FREQ=1440, SEG_STEPS=60, PWM_W=8 → CYCLES_PER_STEP=4)
REQ-034 Reset, then CYCLE with dir=0 → hue_out increments every 4 clocks; at 359→0 wrap_pulse is high for exactly 1 cycle; with dir=1, 0→359 pulses.
REQ-035 cmd_hue=90 accepted → cmd_ready low until the next tick; hue_out=90; duties R=128, G=255, B=0; red_led high 128 of every 255 cycles.
REQ-036 cmd_hue=400 → hue_out=0 at the next tick; a command presented in the tick cycle applies one tick later.
REQ-037 BOUNCE from hue 358 → 359, then 358, then 357; wrap_pulse at the 359→358 step; from 1 going down → 0, then 1, with a pulse.
REQ-038 OFF mode at hue 90 → all LEDs low from the next cycle, hue_out held at 90; rst mid-pending → cmd_ready=1, hue_out=0.
REQ-039 Hue 0 with brightness=128 → red duty 128 with RGB_BRIGHTNESS_EN defined, 255 without it.
